// File: rtl/riscv_if_biu_pkg.sv
// Shared types for the instruction-fetch bus interface unit.
// The parcel entry layout is the one stored in the parcel queue and presented to IF.
package riscv_state_pkg;

    localparam int unsigned BIU_XLEN        = 32;
    localparam int unsigned BIU_PARCEL_SIZE = 32;

    localparam logic [BIU_PARCEL_SIZE/16-1:0] PARCEL_VALID_ALL = '1;

    typedef struct packed {
        logic [BIU_XLEN-1:0]        pc;
        logic [BIU_PARCEL_SIZE-1:0] data;
        logic                       misaligned;
        logic                       page_fault;
    } biu_parcel_t;

endpackage

// File: rtl/riscv_if_biu_if.sv
// Instruction memory bus: in-order word reads with request/ack and a separate response strobe.
interface riscv_if_biu_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic [XLEN-1:0] mem_adr;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            mem_err;

    modport master (
        output mem_req, mem_adr,
        input  mem_ack, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_adr,
        output mem_ack, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/riscv_if_biu_queue.sv
// Synchronous FIFO with a synchronous clear; clear overrides push and pop in the same cycle.
// Callers guarantee no push when full and no pop when empty.
module riscv_if_biu_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (pop_i)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;

endmodule

// File: rtl/riscv_if_biu.sv
// Instruction-fetch BIU: issues in-order word reads for next-PC requests and returns tagged parcels.
// inflight + parcel-queue occupancy is capped at DEPTH, so the parcel queue can never overflow.
module riscv_if_biu
    import riscv_state_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     PARCEL_SIZE = 32,
    parameter int unsigned     DEPTH       = 2,
    parameter logic [XLEN-1:0] PC_INIT     = 'h200
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [XLEN-1:0]          if_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic                     if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    riscv_if_biu_if.master           mem
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PC_INIT[1:0] != 2'b00) begin : g_bad_cfg
        $error("riscv_if_biu: DEPTH must be a power of 2 >= 2 and PC_INIT word aligned");
    end

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW:0]   used;
    logic          credit, issue_ok, aligned;
    logic          accept_bus, accept_mis;
    logic          resp_v, resp_keep, resp_drop;

    logic [XLEN-1:0] pcq_dout;
    logic            pcq_empty, pcq_full;
    logic [CW-1:0]   pcq_cnt;

    biu_parcel_t   pq_din, pq_dout;
    logic          pq_push, pq_pop, pq_empty, pq_full, pq_valid, head_show;
    logic [CW-1:0] pq_cnt;

    assign used     = {1'b0, inflight_q} + {1'b0, pq_cnt};
    assign credit   = (used < (CW+1)'(DEPTH));
    assign issue_ok = rstn & credit & ~if_stall & ~if_flush;
    assign aligned  = (if_nxt_pc[1:0] == 2'b00);

    assign mem.mem_req = issue_ok & aligned;
    assign mem.mem_adr = rstn ? {if_nxt_pc[XLEN-1:2], 2'b00} : '0;

    assign accept_bus = mem.mem_req & mem.mem_ack;
    // A misaligned fetch bypasses the bus, so it waits for the bus to drain to stay in order.
    assign accept_mis = issue_ok & ~aligned & (inflight_q == '0);
    assign if_stall_nxt_pc = ~(accept_bus | accept_mis);

    // Responses with nothing outstanding (e.g. left over across a reset) are ignored.
    assign resp_v    = mem.mem_rvalid & (inflight_q != '0);
    assign resp_drop = resp_v & (discard_q != '0);
    assign resp_keep = resp_v & (discard_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (accept_bus) inflight_d = inflight_d + CW'(1);
        if (resp_v)     inflight_d = inflight_d - CW'(1);
        if (if_flush)       discard_d = inflight_q - CW'(resp_v);
        else if (resp_drop) discard_d = discard_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    riscv_if_biu_queue #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (if_flush),
        .push_i  (accept_bus),
        .din_i   (if_nxt_pc),
        .pop_i   (resp_keep),
        .dout_o  (pcq_dout),
        .empty_o (pcq_empty),
        .full_o  (pcq_full),
        .count_o (pcq_cnt)
    );

    always_comb begin
        pq_din.pc         = pcq_dout;
        pq_din.data       = mem.mem_rdata;
        pq_din.misaligned = 1'b0;
        pq_din.page_fault = mem.mem_err;
        if (accept_mis) begin
            pq_din.pc         = if_nxt_pc;
            pq_din.data       = '0;
            pq_din.misaligned = 1'b1;
            pq_din.page_fault = 1'b0;
        end
    end

    assign pq_push   = resp_keep | accept_mis;
    assign pq_valid  = rstn & ~pq_empty & ~if_flush;
    assign pq_pop    = pq_valid & ~if_stall;
    assign head_show = rstn & ~pq_empty;

    riscv_if_biu_queue #(
        .WIDTH ($bits(biu_parcel_t)),
        .DEPTH (DEPTH)
    ) u_parcel_queue (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (if_flush),
        .push_i  (pq_push),
        .din_i   (pq_din),
        .pop_i   (pq_pop),
        .dout_o  (pq_dout),
        .empty_o (pq_empty),
        .full_o  (pq_full),
        .count_o (pq_cnt)
    );

    assign if_parcel_valid      = pq_valid ? PARCEL_VALID_ALL : '0;
    assign if_parcel            = head_show ? pq_dout.data : '0;
    assign if_parcel_pc         = head_show ? pq_dout.pc : '0;
    assign if_parcel_misaligned = head_show & pq_dout.misaligned;
    assign if_parcel_page_fault = head_show & pq_dout.page_fault;

    a_pq_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(pq_push && pq_full && !if_flush));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(accept_bus && pcq_full && !if_flush));
    a_pcq_has_tag: assert property (@(posedge clk) disable iff (!rstn)
        !(resp_keep && pcq_empty));
    a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rstn)
        pcq_cnt == inflight_q - discard_q);

endmodule

// File: tb/tb_riscv_if_biu.sv
// Directed bench for riscv_if_biu: fixed cycle schedules with hand-computed parcel expectations.
// Memory model returns rdata = addr ^ 0xDEAD0000 one cycle after acceptance unless held.
module tb_riscv_if_biu;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_nxt_pc;
    logic        if_stall;
    logic        if_flush;
    logic        if_stall_nxt_pc;
    logic [31:0] if_parcel;
    logic [31:0] if_parcel_pc;
    logic [1:0]  if_parcel_valid;
    logic        if_parcel_misaligned;
    logic        if_parcel_page_fault;

    logic        resp_hold;
    logic [31:0] err_adr;
    logic [31:0] rq[$];

    int n_vec = 0;
    int n_err = 0;

    riscv_if_biu_if #(.XLEN(32)) bus ();

    riscv_if_biu #(
        .XLEN        (32),
        .PARCEL_SIZE (32),
        .DEPTH       (2),
        .PC_INIT     (32'h200)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem                  (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: accepts are sampled at the negedge, answered from the following cycle.
    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] r;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.mem_req && bus.mem_ack;
            a   = bus.mem_adr;
            @(posedge clk);
            #2;
            if (acc) rq.push_back(a);
            if (!resp_hold && rq.size() > 0) begin
                r = rq.pop_front();
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = r ^ 32'hDEAD_0000;
                bus.mem_err    = (r == err_adr);
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
                bus.mem_err    = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] data,
                            input logic mis, input logic pf);
        chk({tag, "_vld"},  64'(if_parcel_valid), 64'h3);
        chk({tag, "_pc"},   64'(if_parcel_pc), 64'(pc));
        chk({tag, "_data"}, 64'(if_parcel), 64'(data));
        chk({tag, "_mis"},  64'(if_parcel_misaligned), 64'(mis));
        chk({tag, "_pf"},   64'(if_parcel_page_fault), 64'(pf));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic stall_nxt);
        chk({tag, "_req"},   64'(bus.mem_req), 64'(req));
        chk({tag, "_stnxt"}, 64'(if_stall_nxt_pc), 64'(stall_nxt));
    endtask

    task automatic chk_acc(input string tag, input logic [31:0] adr);
        chk_req(tag, 1'b1, 1'b0);
        chk({tag, "_adr"}, 64'(bus.mem_adr), 64'(adr));
    endtask

    task automatic cleanup();
        cyc();
        if_flush  = 1'b1;
        if_stall  = 1'b1;
        resp_hold = 1'b0;
        cyc();
        if_flush = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        rstn      = 1'b0;
        if_nxt_pc = 32'h200;
        if_stall  = 1'b0;
        if_flush  = 1'b0;
        resp_hold = 1'b0;
        err_adr   = 32'hFFFF_FFFF;
        bus.mem_ack = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        smp();
        chk_req("rst", 1'b0, 1'b1);
        chk("rst_vld", 64'(if_parcel_valid), 64'h0);
        chk("rst_adr", 64'(bus.mem_adr), 64'h0);
        chk("rst_pc",  64'(if_parcel_pc), 64'h0);
        chk("rst_dat", 64'(if_parcel), 64'h0);

        // Sequential sweep 0x200.. with 1-cycle responses
        cyc(); rstn = 1'b1;
        smp(); chk_acc("sw0", 32'h200);
        cyc(); if_nxt_pc = 32'h204;
        smp(); chk_acc("sw1", 32'h204);
        cyc(); if_nxt_pc = 32'h208;
        smp(); chk_req("sw2_full", 1'b0, 1'b1);
        chk_head("sw2", 32'h200, 32'hDEAD_0200, 1'b0, 1'b0);
        cyc();
        smp(); chk_head("sw3", 32'h204, 32'hDEAD_0204, 1'b0, 1'b0);
        chk_acc("sw3", 32'h208);
        cyc(); if_nxt_pc = 32'h20C;
        smp(); chk_acc("sw4", 32'h20C);
        cyc(); if_nxt_pc = 32'h210;
        smp(); chk_head("sw5", 32'h208, 32'hDEAD_0208, 1'b0, 1'b0);
        cleanup();

        // Consumer stall fills DEPTH, head held, then drains in order
        if_stall = 1'b0; if_nxt_pc = 32'h500;
        smp(); chk_acc("st0", 32'h500);
        cyc(); if_nxt_pc = 32'h504;
        smp(); chk_acc("st1", 32'h504);
        cyc(); if_nxt_pc = 32'h508; if_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            smp();
            chk_req($sformatf("st_hold%0d", k), 1'b0, 1'b1);
            chk_head($sformatf("st_hold%0d", k), 32'h500, 32'hDEAD_0500, 1'b0, 1'b0);
        end
        cyc(); if_stall = 1'b0;
        smp(); chk("st_rel_stnxt", 64'(if_stall_nxt_pc), 64'h1);
        chk_head("st_rel", 32'h500, 32'hDEAD_0500, 1'b0, 1'b0);
        cyc();
        smp(); chk_head("st_d1", 32'h504, 32'hDEAD_0504, 1'b0, 1'b0);
        chk_acc("st_d1", 32'h508);
        cyc(); if_nxt_pc = 32'h50C;
        cyc();
        smp(); chk_head("st_d2", 32'h508, 32'hDEAD_0508, 1'b0, 1'b0);
        cleanup();

        // Flush with two requests in flight
        if_stall = 1'b0; resp_hold = 1'b1; if_nxt_pc = 32'h600;
        smp(); chk_acc("fl0", 32'h600);
        cyc(); if_nxt_pc = 32'h604;
        smp(); chk_acc("fl1", 32'h604);
        cyc(); if_nxt_pc = 32'h400; if_flush = 1'b1;
        smp(); chk_req("fl2", 1'b0, 1'b1);
        chk("fl2_vld", 64'(if_parcel_valid), 64'h0);
        cyc(); if_flush = 1'b0; resp_hold = 1'b0;
        smp(); chk("fl3_vld", 64'(if_parcel_valid), 64'h0);
        chk("fl3_stnxt", 64'(if_stall_nxt_pc), 64'h1);
        cyc();
        smp(); chk("fl4_vld", 64'(if_parcel_valid), 64'h0);
        chk_acc("fl4", 32'h400);
        cyc(); if_nxt_pc = 32'h404;
        smp(); chk("fl5_vld", 64'(if_parcel_valid), 64'h0);
        cyc();
        smp(); chk_head("fl6", 32'h400, 32'hDEAD_0400, 1'b0, 1'b0);
        cleanup();

        // Misaligned fetch, and a misaligned fetch waiting for the bus to drain
        if_stall = 1'b0; if_nxt_pc = 32'h202;
        smp(); chk_req("mis0", 1'b0, 1'b0);
        cyc(); if_nxt_pc = 32'h208;
        smp(); chk_head("mis1", 32'h202, 32'h0, 1'b1, 1'b0);
        chk_acc("mis1", 32'h208);
        cyc(); if_nxt_pc = 32'h20A;
        smp(); chk_req("mis2_wait", 1'b0, 1'b1);
        cyc();
        smp(); chk_head("mis3", 32'h208, 32'hDEAD_0208, 1'b0, 1'b0);
        chk_req("mis3", 1'b0, 1'b0);
        cyc(); if_nxt_pc = 32'h210;
        smp(); chk_head("mis4", 32'h20A, 32'h0, 1'b1, 1'b0);
        cleanup();

        // Bus error on 0x300 only
        err_adr = 32'h300;
        if_stall = 1'b0; if_nxt_pc = 32'h300;
        smp(); chk_acc("pf0", 32'h300);
        cyc(); if_nxt_pc = 32'h304;
        smp(); chk_acc("pf1", 32'h304);
        cyc(); if_nxt_pc = 32'h308;
        smp(); chk_head("pf2", 32'h300, 32'hDEAD_0300, 1'b0, 1'b1);
        cyc();
        smp(); chk_head("pf3", 32'h304, 32'hDEAD_0304, 1'b0, 1'b0);
        cleanup();
        err_adr = 32'hFFFF_FFFF;

        // Reset mid-transaction (occ=1, inflight=1); stale response must not appear
        if_stall = 1'b0; if_nxt_pc = 32'h700;
        smp(); chk_acc("rr0", 32'h700);
        cyc(); if_nxt_pc = 32'h704;
        smp(); chk_acc("rr1", 32'h704);
        cyc(); resp_hold = 1'b1; if_stall = 1'b1; rstn = 1'b0;
        smp(); chk_req("rr2", 1'b0, 1'b1);
        chk("rr2_vld", 64'(if_parcel_valid), 64'h0);
        chk("rr2_adr", 64'(bus.mem_adr), 64'h0);
        chk("rr2_pc",  64'(if_parcel_pc), 64'h0);
        chk("rr2_dat", 64'(if_parcel), 64'h0);
        cyc(); rstn = 1'b1; resp_hold = 1'b0;
        smp(); chk("rr3_vld", 64'(if_parcel_valid), 64'h0);
        cyc();
        smp(); chk("rr4_vld", 64'(if_parcel_valid), 64'h0);
        cyc(); if_stall = 1'b0; if_nxt_pc = 32'h800;
        smp(); chk_acc("rr5", 32'h800);
        cyc();
        smp(); chk("rr6_vld", 64'(if_parcel_valid), 64'h0);
        cyc();
        smp(); chk_head("rr7", 32'h800, 32'hDEAD_0800, 1'b0, 1'b0);
        cleanup();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
